// File: rtl/vanilla_remote_load_wb_buffer.sv
// Remote load response writeback buffer: formats responses at enqueue, queues them in order,
// and presents the head to the integer or FP register-file writeback port with starvation escalation.
module vanilla_remote_load_wb_buffer #(
  parameter int els_p         = 2,
  parameter int stall_limit_p = 8
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        v_i,
  input  logic [42:0] resp_i,
  output logic        ready_o,
  output logic        int_v_o,
  output logic        float_v_o,
  output logic [4:0]  wb_addr_o,
  output logic [31:0] wb_data_o,
  input  logic        int_yumi_i,
  input  logic        float_yumi_i,
  output logic        force_wb_o
);

  localparam int ptr_w = $clog2(els_p);
  localparam int cnt_w = ptr_w + 1;

  typedef struct packed {
    logic        float_wb;
    logic [4:0]  reg_id;
    logic        is_unsigned_op;
    logic        is_byte_op;
    logic        is_hex_op;
    logic [1:0]  part_sel;
    logic [31:0] data;
  } remote_load_resp_s;

  typedef struct packed {
    logic        float_wb;
    logic [4:0]  addr;
    logic [31:0] data;
  } entry_s;

  remote_load_resp_s resp;
  entry_s            mem [els_p];
  entry_s            head;
  logic [ptr_w-1:0]  rptr, wptr;
  logic [cnt_w-1:0]  count;
  logic [7:0]        wait_cnt;
  logic              empty, full, is_x0, enq, deq;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [31:0]       fmt_data;

  assign resp  = resp_i;
  assign empty = (count == '0);
  assign full  = (count == cnt_w'(els_p));

  // Writes to x0 complete the handshake but never occupy a slot; f0 is a real register.
  assign is_x0 = ~resp.float_wb & (resp.reg_id == 5'd0);
  assign enq   = v_i & ~full & ~is_x0;
  assign deq   = (int_yumi_i | float_yumi_i) & ~empty;

  assign byte_sel = 8'(resp.data >> {resp.part_sel, 3'b000});
  assign half_sel = 16'(resp.data >> {resp.part_sel[1], 4'b0000});

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    fmt_data = resp.data;
    if (resp.is_byte_op)
      fmt_data = resp.is_unsigned_op ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
    else if (resp.is_hex_op)
      fmt_data = resp.is_unsigned_op ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
  end

  // NOTE: the storage array is not reset; pointers and count define validity and outputs are gated while empty.
  always_ff @(posedge clk_i) begin
    if (enq) mem[wptr] <= '{float_wb: resp.float_wb, addr: resp.reg_id, data: fmt_data};
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rptr     <= '0;
      wptr     <= '0;
      count    <= '0;
      wait_cnt <= '0;
    end else begin
      if (enq) wptr <= wptr + ptr_w'(1);
      if (deq) rptr <= rptr + ptr_w'(1);
      unique case ({enq, deq})
        2'b10:   count <= count + cnt_w'(1);
        2'b01:   count <= count - cnt_w'(1);
        default: count <= count;
      endcase
      // Starvation tracking restarts for each new head and saturates at the limit.
      if (deq || empty)
        wait_cnt <= '0;
      else if (wait_cnt != 8'(stall_limit_p))
        wait_cnt <= wait_cnt + 8'd1;
    end
  end

  assign head       = mem[rptr];
  assign ready_o    = ~full;
  assign int_v_o    = ~empty & ~head.float_wb;
  assign float_v_o  = ~empty & head.float_wb;
  assign wb_addr_o  = empty ? 5'd0 : head.addr;
  assign wb_data_o  = empty ? 32'd0 : head.data;
  assign force_wb_o = (wait_cnt == 8'(stall_limit_p));

endmodule

// File: tb/tb_vanilla_remote_load_wb_buffer.sv
// Self-checking bench for vanilla_remote_load_wb_buffer: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_vanilla_remote_load_wb_buffer;

  localparam int DEPTH = 2;
  localparam int LIMIT = 8;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        v_i = 1'b0;
  logic [42:0] resp_i = '0;
  logic        int_yumi_i = 1'b0;
  logic        float_yumi_i = 1'b0;
  logic        ready_o, int_v_o, float_v_o, force_wb_o;
  logic [4:0]  wb_addr_o;
  logic [31:0] wb_data_o;

  always #5 clk = ~clk;

  vanilla_remote_load_wb_buffer #(.els_p(DEPTH), .stall_limit_p(LIMIT)) dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .v_i          (v_i),
    .resp_i       (resp_i),
    .ready_o      (ready_o),
    .int_v_o      (int_v_o),
    .float_v_o    (float_v_o),
    .wb_addr_o    (wb_addr_o),
    .wb_data_o    (wb_data_o),
    .int_yumi_i   (int_yumi_i),
    .float_yumi_i (float_yumi_i),
    .force_wb_o   (force_wb_o)
  );

  typedef struct {
    bit        fl;
    bit [4:0]  addr;
    bit [31:0] data;
  } ent_t;

  ent_t mq[$];
  int   wt = 0;
  int   n_pass = 0;
  int   n_total = 0;

  function automatic bit [42:0] mk(bit fl, bit [4:0] rd, bit uns, bit byt, bit hex, bit [1:0] p, bit [31:0] d);
    return {fl, rd, uns, byt, hex, p, d};
  endfunction

  // Expected formatted data, computed arithmetically from the response fields.
  function automatic bit [31:0] ref_fmt(bit [42:0] r);
    int unsigned d, v, p;
    d = r[31:0];
    p = r[33:32];
    v = d;
    if (r[35]) begin
      v = (d >> (8 * p)) & 32'hFF;
      if (!r[36] && v >= 128) v = v + 32'hFFFF_FF00;
    end else if (r[34]) begin
      v = (d >> (16 * (p / 2))) & 32'hFFFF;
      if (!r[36] && v >= 32'h8000) v = v + 32'hFFFF_0000;
    end
    return v;
  endfunction

  // {ready, int_v, float_v, force} as the model predicts.
  function automatic bit [3:0] exp_flags();
    bit hv;
    bit hf;
    hv = (mq.size() > 0);
    hf = hv ? mq[0].fl : 1'b0;
    return {mq.size() < DEPTH, hv && !hf, hv && hf, wt == LIMIT};
  endfunction

  task automatic drive(bit v, bit [42:0] r, bit iy, bit fy);
    v_i          = v;
    resp_i       = r;
    int_yumi_i   = iy;
    float_yumi_i = fy;
  endtask

  // One clock: advance the model by the rules of the buffer, then settle past the edge.
  task automatic tick();
    bit        acc, dq, was_empty, rst;
    bit [42:0] r;
    ent_t      e;
    rst       = reset_i;
    r         = resp_i;
    acc       = v_i && (mq.size() < DEPTH);
    dq        = (int_yumi_i || float_yumi_i) && (mq.size() > 0);
    was_empty = (mq.size() == 0);
    @(posedge clk);
    if (rst) begin
      mq.delete();
      wt = 0;
    end else begin
      if (dq) void'(mq.pop_front());
      if (acc && !(r[42] == 1'b0 && r[41:37] == 5'd0)) begin
        e.fl   = r[42];
        e.addr = r[41:37];
        e.data = ref_fmt(r);
        mq.push_back(e);
      end
      if (dq || was_empty) wt = 0;
      else if (wt < LIMIT) wt++;
    end
    #1;
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    drive(0, '0, 0, 0);
    tick();
    tick();
    reset_i = 1'b0;
    tick();
    n_total++;
    if ({ready_o, int_v_o, float_v_o, force_wb_o} !== 4'b1000)
      $display("FAIL reset_flags: got %b want 1000", {ready_o, int_v_o, float_v_o, force_wb_o});
    else n_pass++;
    n_total++;
    if (wb_addr_o !== 5'd0) $display("FAIL reset_addr: got %0d want 0", wb_addr_o);
    else n_pass++;
    n_total++;
    if (wb_data_o !== 32'd0) $display("FAIL reset_data: got %h want 0", wb_data_o);
    else n_pass++;
  endtask

  task automatic test_signed_byte();
    drive(1, mk(0, 5, 0, 1, 0, 2, 32'h1280_3456), 0, 0);
    tick();
    drive(0, '0, 0, 0);
    n_total++;
    if ({int_v_o, float_v_o} !== 2'b10) $display("FAIL sbyte_valid: got %b want 10", {int_v_o, float_v_o});
    else n_pass++;
    n_total++;
    if (wb_addr_o !== 5'd5) $display("FAIL sbyte_addr: got %0d want 5", wb_addr_o);
    else n_pass++;
    n_total++;
    if (wb_data_o !== 32'hFFFF_FF80) $display("FAIL sbyte_data: got %h want ffffff80", wb_data_o);
    else n_pass++;
    drive(0, '0, 1, 0);
    tick();
    drive(0, '0, 0, 0);
    n_total++;
    if (int_v_o !== 1'b0) $display("FAIL sbyte_drain: got int_v %b want 0", int_v_o);
    else n_pass++;
  endtask

  task automatic test_unsigned_hex();
    drive(1, mk(0, 9, 1, 0, 1, 3, 32'hBEEF_0001), 0, 0);
    tick();
    drive(0, '0, 0, 0);
    n_total++;
    if (wb_data_o !== 32'h0000_BEEF) $display("FAIL uhex_data: got %h want 0000beef", wb_data_o);
    else n_pass++;
    n_total++;
    if ({int_v_o, wb_addr_o} !== {1'b1, 5'd9}) $display("FAIL uhex_head: got v=%b a=%0d want v=1 a=9", int_v_o, wb_addr_o);
    else n_pass++;
    drive(0, '0, 1, 0);
    tick();
    drive(0, '0, 0, 0);
    n_total++;
    if ({ready_o, int_v_o, float_v_o, force_wb_o} !== exp_flags())
      $display("FAIL uhex_drain: got %b want %b", {ready_o, int_v_o, float_v_o, force_wb_o}, exp_flags());
    else n_pass++;
  endtask

  task automatic test_mixed_order();
    bit [42:0] r4;
    r4 = mk(0, 4, 0, 0, 0, 0, 32'h4444_0004);
    drive(1, mk(0, 3, 0, 0, 0, 0, 32'hA0A0_0003), 0, 0);
    tick();
    n_total++;
    if (ready_o !== 1'b1) $display("FAIL mixed_ready1: got %b want 1", ready_o);
    else n_pass++;
    drive(1, mk(1, 7, 0, 0, 0, 0, 32'hF7F7_0007), 0, 0);
    tick();
    n_total++;
    if (ready_o !== 1'b0) $display("FAIL mixed_full: got ready %b want 0", ready_o);
    else n_pass++;
    drive(1, r4, 0, 0);
    tick();
    n_total++;
    if ({ready_o, int_v_o, wb_addr_o, wb_data_o} !== {1'b0, 1'b1, 5'd3, 32'hA0A0_0003})
      $display("FAIL mixed_head_x3: got r=%b v=%b a=%0d d=%h want r=0 v=1 a=3 d=a0a00003", ready_o, int_v_o, wb_addr_o, wb_data_o);
    else n_pass++;
    drive(1, r4, 1, 0);
    tick();
    n_total++;
    if ({ready_o, int_v_o, float_v_o, wb_addr_o} !== {1'b1, 1'b0, 1'b1, 5'd7})
      $display("FAIL mixed_head_f7: got r=%b iv=%b fv=%b a=%0d want r=1 iv=0 fv=1 a=7", ready_o, int_v_o, float_v_o, wb_addr_o);
    else n_pass++;
    drive(1, r4, 0, 1);
    tick();
    n_total++;
    if ({int_v_o, float_v_o, wb_addr_o, wb_data_o} !== {1'b1, 1'b0, 5'd4, 32'h4444_0004})
      $display("FAIL mixed_head_x4: got iv=%b fv=%b a=%0d d=%h want iv=1 fv=0 a=4 d=44440004", int_v_o, float_v_o, wb_addr_o, wb_data_o);
    else n_pass++;
    drive(0, '0, 1, 0);
    tick();
    drive(0, '0, 0, 0);
    n_total++;
    if ({ready_o, int_v_o, float_v_o, force_wb_o} !== 4'b1000)
      $display("FAIL mixed_empty: got %b want 1000", {ready_o, int_v_o, float_v_o, force_wb_o});
    else n_pass++;
  endtask

  task automatic test_x0_drop();
    drive(1, mk(0, 0, 0, 0, 0, 0, 32'h0000_1111), 0, 0);
    tick();
    tick();
    drive(0, '0, 0, 0);
    n_total++;
    if ({ready_o, int_v_o, float_v_o, force_wb_o} !== 4'b1000)
      $display("FAIL x0_drop: got %b want 1000", {ready_o, int_v_o, float_v_o, force_wb_o});
    else n_pass++;
    drive(1, mk(1, 0, 0, 0, 0, 0, 32'h0000_F00D), 0, 0);
    tick();
    drive(0, '0, 0, 0);
    n_total++;
    if ({int_v_o, float_v_o, wb_addr_o, wb_data_o} !== {1'b0, 1'b1, 5'd0, 32'h0000_F00D})
      $display("FAIL f0_kept: got iv=%b fv=%b a=%0d d=%h want iv=0 fv=1 a=0 d=0000f00d", int_v_o, float_v_o, wb_addr_o, wb_data_o);
    else n_pass++;
    drive(0, '0, 0, 1);
    tick();
    drive(0, '0, 0, 0);
    n_total++;
    if ({ready_o, int_v_o, float_v_o, force_wb_o} !== 4'b1000)
      $display("FAIL f0_drain: got %b want 1000", {ready_o, int_v_o, float_v_o, force_wb_o});
    else n_pass++;
  endtask

  task automatic test_starvation();
    bit [42:0] r2;
    r2 = mk(0, 11, 0, 0, 0, 0, 32'h0000_005B);
    drive(1, mk(0, 10, 0, 0, 0, 0, 32'h0000_005A), 0, 0);
    tick();
    for (int i = 1; i <= 10; i++) begin
      n_total++;
      if (force_wb_o !== 1'(i >= 9)) $display("FAIL starve_first cycle %0d: got %b want %b", i, force_wb_o, 1'(i >= 9));
      else n_pass++;
      drive(i == 1, r2, 0, 0);
      if (i < 10) tick();
    end
    drive(0, '0, 1, 0);
    tick();
    drive(0, '0, 0, 0);
    n_total++;
    if ({force_wb_o, int_v_o, wb_addr_o} !== {1'b0, 1'b1, 5'd11})
      $display("FAIL starve_release: got f=%b v=%b a=%0d want f=0 v=1 a=11", force_wb_o, int_v_o, wb_addr_o);
    else n_pass++;
    for (int i = 1; i <= 9; i++) begin
      n_total++;
      if (force_wb_o !== 1'(i == 9)) $display("FAIL starve_second cycle %0d: got %b want %b", i, force_wb_o, 1'(i == 9));
      else n_pass++;
      if (i < 9) tick();
    end
    drive(0, '0, 1, 0);
    tick();
    drive(0, '0, 0, 0);
    n_total++;
    if ({ready_o, int_v_o, float_v_o, force_wb_o} !== 4'b1000)
      $display("FAIL starve_drain: got %b want 1000", {ready_o, int_v_o, float_v_o, force_wb_o});
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    drive(1, mk(0, 12, 0, 0, 0, 0, 32'h0000_000C), 0, 0);
    tick();
    drive(1, mk(1, 13, 0, 0, 0, 0, 32'h0000_000D), 0, 0);
    tick();
    drive(0, '0, 0, 0);
    for (int i = 0; i < 10; i++) tick();
    n_total++;
    if ({ready_o, int_v_o, float_v_o, force_wb_o} !== 4'b0101)
      $display("FAIL rstmid_pre: got %b want 0101", {ready_o, int_v_o, float_v_o, force_wb_o});
    else n_pass++;
    reset_i = 1'b1;
    drive(1, mk(0, 14, 0, 0, 0, 0, 32'h0000_000E), 1, 0);
    tick();
    reset_i = 1'b0;
    drive(0, '0, 0, 0);
    n_total++;
    if ({ready_o, int_v_o, float_v_o, force_wb_o} !== 4'b1000)
      $display("FAIL rstmid_clear: got %b want 1000", {ready_o, int_v_o, float_v_o, force_wb_o});
    else n_pass++;
    drive(1, mk(0, 15, 0, 0, 0, 0, 32'h0000_0015), 0, 0);
    tick();
    drive(0, '0, 0, 0);
    n_total++;
    if ({int_v_o, wb_addr_o, wb_data_o} !== {1'b1, 5'd15, 32'h0000_0015})
      $display("FAIL rstmid_new: got v=%b a=%0d d=%h want v=1 a=15 d=00000015", int_v_o, wb_addr_o, wb_data_o);
    else n_pass++;
    drive(0, '0, 1, 0);
    tick();
    drive(0, '0, 0, 0);
    n_total++;
    if ({ready_o, int_v_o, float_v_o, force_wb_o} !== 4'b1000)
      $display("FAIL rstmid_only_new: got %b want 1000", {ready_o, int_v_o, float_v_o, force_wb_o});
    else n_pass++;
  endtask

  task automatic test_random();
    bit [42:0] r;
    bit        iy, fy;
    for (int i = 0; i < 400; i++) begin
      r = mk(1'($urandom), ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom), 1'($urandom),
             1'($urandom), 1'($urandom), 2'($urandom), $urandom);
      iy = 1'b0;
      fy = 1'b0;
      if (mq.size() > 0 && $urandom_range(0, 2) == 0) begin
        iy = !mq[0].fl;
        fy = mq[0].fl;
      end
      reset_i = ($urandom_range(0, 99) == 0);
      drive(1'($urandom), r, iy, fy);
      tick();
      n_total++;
      if ({ready_o, int_v_o, float_v_o, force_wb_o} !== exp_flags())
        $display("FAIL rand_flags cycle %0d: got %b want %b", i, {ready_o, int_v_o, float_v_o, force_wb_o}, exp_flags());
      else n_pass++;
      if (mq.size() > 0) begin
        n_total++;
        if ({wb_addr_o, wb_data_o} !== {mq[0].addr, mq[0].data})
          $display("FAIL rand_head cycle %0d: got a=%0d d=%h want a=%0d d=%h", i, wb_addr_o, wb_data_o, mq[0].addr, mq[0].data);
        else n_pass++;
      end
    end
    reset_i = 1'b0;
    drive(0, '0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_signed_byte();
    test_unsigned_hex();
    test_mixed_order();
    test_x0_drop();
    test_starvation();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
